// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS receive checker: lock FSM states,
// default PRBS31 constants and a popcount helper for error accounting.
package prbs_pkg;

  // Lock state machine states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SYNC   = 2'd2,
    ST_LOCKED = 2'd3
  } check_state_t;

  // PRBS31: x^31 + x^28 + 1
  localparam int                PRBS31_WIDTH = 31;
  localparam logic [30:0]       PRBS31_POLY  = 31'h10000001;

  // popcount operates on a fixed-width vector; narrower callers zero-extend
  localparam int POPCOUNT_IN_WIDTH  = 64;
  localparam int POPCOUNT_OUT_WIDTH = 7;

  function automatic logic [POPCOUNT_OUT_WIDTH-1:0] popcount(
    input logic [POPCOUNT_IN_WIDTH-1:0] bits
  );
    logic [POPCOUNT_OUT_WIDTH-1:0] total;
    total = '0;
    for (int i = 0; i < POPCOUNT_IN_WIDTH; i++) begin
      total = total + {{(POPCOUNT_OUT_WIDTH-1){1'b0}}, bits[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR core: advances state_in by DATA_WIDTH shifts, mixing
// in data_in (MSB first). data_out carries the shifted-out feedback bits,
// earliest in the MSB; state_out is the advanced state.
module lfsr #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter bit                    REVERSE     = 1'b0,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int TOTAL         = LFSR_WIDTH + DATA_WIDTH;
  localparam bit IS_GALOIS     = (LFSR_CONFIG == "GALOIS");
  localparam bit USE_REDUCTION = (STYLE == "REDUCTION");

  function automatic logic [LFSR_WIDTH-1:0] rev_state(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rev_data(input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
    return r;
  endfunction

  // Bit-serial reference of one word step; vec = {state, data}, result = {state, data}
  function automatic logic [TOTAL-1:0] advance(input logic [TOTAL-1:0] vec);
    logic [LFSR_WIDTH-1:0] st;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  fb;
    st   = vec[TOTAL-1:DATA_WIDTH];
    din  = vec[DATA_WIDTH-1:0];
    dout = '0;
    if (REVERSE) begin
      st  = rev_state(st);
      din = rev_data(din);
    end
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      fb = st[LFSR_WIDTH-1] ^ din[i];
      if (IS_GALOIS) begin
        st = {st[LFSR_WIDTH-2:0], 1'b0};
        if (fb) st = st ^ LFSR_POLY;
      end else begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ st[j-1];
        end
        st = {st[LFSR_WIDTH-2:0], fb};
      end
      dout[i] = fb;
    end
    if (REVERSE) begin
      st   = rev_state(st);
      dout = rev_data(dout);
    end
    return {st, dout};
  endfunction

  // The step is linear over GF(2): output bit k is the XOR of the inputs
  // whose unit vector sets bit k, which gives a constant mask per output
  function automatic logic [TOTAL-1:0] out_mask(input int k);
    logic [TOTAL-1:0] m;
    logic [TOTAL-1:0] r;
    m = '0;
    for (int i = 0; i < TOTAL; i++) begin
      r    = advance(TOTAL'(1) << i);
      m[i] = r[k];
    end
    return m;
  endfunction

  logic [TOTAL-1:0] in_vec;
  logic [TOTAL-1:0] out_vec;

  assign in_vec                = {state_in, data_in};
  assign {state_out, data_out} = out_vec;

  if (USE_REDUCTION) begin : g_reduction
    for (genvar k = 0; k < TOTAL; k++) begin : g_bit
      localparam logic [TOTAL-1:0] MASK = out_mask(k);
      assign out_vec[k] = ^(in_vec & MASK);
    end
  end else begin : g_loop
    // Unrolled shift loop evaluated every cycle
    always_comb begin
      out_vec = advance(in_vec);
    end
  end

endmodule

// File: rtl/prbs_check_ctrl.sv
// PRBS receive-side checker: self-synchronises a seed from the incoming
// stream, predicts each next word with the lfsr core, runs the lock FSM
// and keeps saturating bit-error and word counters while locked.
module prbs_check_ctrl
  import prbs_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = PRBS31_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = PRBS31_POLY,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  locked,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] error_bits,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  word_count
);

  // Words needed to fill every seed bit from the received stream
  localparam int FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FILL_W     = $clog2(FILL_WORDS + 1);
  localparam int CLEAN_W    = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W      = $clog2(UNLOCK_COUNT + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILL_WORDS - 1);
  localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(UNLOCK_COUNT - 1);

  check_state_t state;

  logic [LFSR_WIDTH-1:0]         seed;
  logic [LFSR_WIDTH-1:0]         seed_free;
  logic [LFSR_WIDTH-1:0]         seed_load;
  logic [DATA_WIDTH-1:0]         predicted;
  logic [DATA_WIDTH-1:0]         mismatch;
  logic [POPCOUNT_OUT_WIDTH-1:0] bit_errors;

  logic [FILL_W-1:0]  fill_cnt;
  logic [CLEAN_W-1:0] clean_cnt;
  logic [BAD_W-1:0]   bad_cnt;

  logic [CNT_WIDTH-1:0] err_base;
  logic [CNT_WIDTH-1:0] word_base;
  logic [CNT_WIDTH:0]   err_sum;
  logic [CNT_WIDTH-1:0] err_next;
  logic [CNT_WIDTH-1:0] word_next;

  // Predictor: with zero data the core free-runs from the seed
  lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_CONFIG("FIBONACCI"),
    .REVERSE    (1'b0),
    .DATA_WIDTH (DATA_WIDTH),
    .STYLE      ("AUTO")
  ) u_predictor (
    .data_in  ('0),
    .state_in (seed),
    .data_out (predicted),
    .state_out(seed_free)
  );

  assign seed_load  = {seed[LFSR_WIDTH-1-DATA_WIDTH:0], data_in};
  assign mismatch   = data_in ^ predicted;
  assign bit_errors = popcount({{(POPCOUNT_IN_WIDTH-DATA_WIDTH){1'b0}}, mismatch});

  // Saturating counter updates; a coincident clear restarts from zero
  always_comb begin
    err_base  = clear ? '0 : error_count;
    word_base = clear ? '0 : word_count;
    err_sum   = {1'b0, err_base}
              + {{(CNT_WIDTH+1-POPCOUNT_OUT_WIDTH){1'b0}}, bit_errors};
    err_next  = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    word_next = (&word_base) ? word_base : word_base + CNT_WIDTH'(1);
  end

  // Lock FSM, seed register, run-length counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      seed        <= '0;
      fill_cnt    <= '0;
      clean_cnt   <= '0;
      bad_cnt     <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_bits  <= '0;
      error_count <= '0;
      word_count  <= '0;
    end else begin
      error <= 1'b0;
      if (clear) begin
        error_count <= '0;
        word_count  <= '0;
      end
      if (!enable) begin
        state     <= ST_IDLE;
        locked    <= 1'b0;
        seed      <= '0;
        fill_cnt  <= '0;
        clean_cnt <= '0;
        bad_cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state    <= ST_FILL;
            seed     <= '0;
            fill_cnt <= '0;
          end
          ST_FILL: begin
            if (data_valid) begin
              seed <= seed_load;
              if (fill_cnt == FILL_LAST) begin
                fill_cnt  <= '0;
                clean_cnt <= '0;
                state     <= ST_SYNC;
              end else begin
                fill_cnt <= fill_cnt + FILL_W'(1);
              end
            end
          end
          ST_SYNC: begin
            if (data_valid) begin
              seed <= seed_load;
              if (mismatch == '0) begin
                if (clean_cnt == CLEAN_LAST) begin
                  clean_cnt <= '0;
                  bad_cnt   <= '0;
                  locked    <= 1'b1;
                  state     <= ST_LOCKED;
                end else begin
                  clean_cnt <= clean_cnt + CLEAN_W'(1);
                end
              end else begin
                clean_cnt <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (data_valid) begin
              seed        <= seed_free;
              error_bits  <= mismatch;
              error       <= |mismatch;
              error_count <= err_next;
              word_count  <= word_next;
              if (|mismatch) begin
                if (bad_cnt == BAD_LAST) begin
                  bad_cnt   <= '0;
                  clean_cnt <= '0;
                  locked    <= 1'b0;
                  state     <= ST_SYNC;
                end else begin
                  bad_cnt <= bad_cnt + BAD_W'(1);
                end
              end else begin
                bad_cnt <= '0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_check_ctrl.sv
// Self-checking bench for prbs_check_ctrl. Expected outputs come from a
// bit-history model of the PRBS31 recurrence b[n] = b[n-31] ^ b[n-28].
module tb_prbs_check_ctrl;

  localparam int          DW      = 8;
  localparam int          CW      = 32;
  localparam int          FILLN   = 4;
  localparam int          LOCKN   = 16;
  localparam int          UNLOCKN = 4;
  localparam longint      CNT_MAX = 64'h00000000FFFFFFFF;

  localparam int P_IDLE   = 0;
  localparam int P_FILL   = 1;
  localparam int P_SYNC   = 2;
  localparam int P_LOCKED = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          locked;
  logic          error;
  logic [DW-1:0] error_bits;
  logic [CW-1:0] error_count;
  logic [CW-1:0] word_count;

  prbs_check_ctrl #(
    .LFSR_WIDTH  (31),
    .LFSR_POLY   (31'h10000001),
    .DATA_WIDTH  (DW),
    .LOCK_COUNT  (LOCKN),
    .UNLOCK_COUNT(UNLOCKN),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .data_in    (data_in),
    .data_valid (data_valid),
    .locked     (locked),
    .error      (error),
    .error_bits (error_bits),
    .error_count(error_count),
    .word_count (word_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    bit            rst;
    bit            enable;
    bit            clear;
    bit            valid;
    logic [DW-1:0] data;
    bit            exp_locked;
    bit            exp_error;
    logic [DW-1:0] exp_bits;
    logic [CW-1:0] exp_ecnt;
    logic [CW-1:0] exp_wcnt;
  } vec_t;

  vec_t vecs[$];
  int   test_count = 0;
  int   fail_count = 0;

  // Reference model state
  int              m_phase;
  int              m_words;
  int              m_clean;
  int              m_bad;
  bit              m_hist[$];
  bit              m_locked;
  bit              m_error;
  logic [DW-1:0]   m_bits;
  longint unsigned m_ecnt;
  longint unsigned m_wcnt;

  logic [30:0]     gen_state;

  function automatic logic [DW-1:0] genWord();
    logic [DW-1:0] w;
    logic          fb;
    for (int i = DW-1; i >= 0; i--) begin
      fb        = gen_state[30] ^ gen_state[27];
      gen_state = {gen_state[29:0], fb};
      w[i]      = fb;
    end
    return w;
  endfunction

  task automatic modelClearHistory();
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
  endtask

  function automatic logic [DW-1:0] modelPredict();
    bit            t[$];
    bit            b;
    logic [DW-1:0] w;
    t = m_hist;
    for (int i = DW-1; i >= 0; i--) begin
      b = t[t.size()-31] ^ t[t.size()-28];
      t.push_back(b);
      w[i] = b;
    end
    return w;
  endfunction

  task automatic modelPush(input logic [DW-1:0] w);
    for (int i = DW-1; i >= 0; i--) m_hist.push_back(w[i]);
    while (m_hist.size() > 31) void'(m_hist.pop_front());
  endtask

  task automatic modelStep(input bit r, input bit en, input bit clr,
                           input bit v, input logic [DW-1:0] d);
    logic [DW-1:0]   pred;
    logic [DW-1:0]   diff;
    longint unsigned sum;
    if (r) begin
      m_phase = P_IDLE; m_words = 0; m_clean = 0; m_bad = 0;
      modelClearHistory();
      m_locked = 0; m_error = 0; m_bits = '0; m_ecnt = 0; m_wcnt = 0;
    end else begin
      m_error = 0;
      if (clr) begin
        m_ecnt = 0;
        m_wcnt = 0;
      end
      if (!en) begin
        m_phase  = P_IDLE;
        m_locked = 0;
      end else if (m_phase == P_IDLE) begin
        m_phase = P_FILL;
        m_words = 0;
        modelClearHistory();
      end else if (v && m_phase == P_FILL) begin
        modelPush(d);
        m_words++;
        if (m_words == FILLN) begin
          m_phase = P_SYNC;
          m_clean = 0;
        end
      end else if (v && m_phase == P_SYNC) begin
        pred = modelPredict();
        m_clean = (d == pred) ? m_clean + 1 : 0;
        modelPush(d);
        if (m_clean == LOCKN) begin
          m_phase  = P_LOCKED;
          m_locked = 1;
          m_bad    = 0;
        end
      end else if (v && m_phase == P_LOCKED) begin
        pred = modelPredict();
        diff = d ^ pred;
        modelPush(pred);
        m_wcnt  = (m_wcnt >= CNT_MAX) ? CNT_MAX : m_wcnt + 1;
        sum     = m_ecnt + longint'($countones(diff));
        m_ecnt  = (sum > CNT_MAX) ? CNT_MAX : sum;
        m_bits  = diff;
        m_error = (diff != '0);
        if (diff != '0) begin
          m_bad++;
          if (m_bad == UNLOCKN) begin
            m_phase  = P_SYNC;
            m_locked = 0;
            m_clean  = 0;
            m_bad    = 0;
          end
        end else begin
          m_bad = 0;
        end
      end
    end
  endtask

  task automatic addVec(input string tag, input bit r, input bit en, input bit clr,
                        input bit v, input logic [DW-1:0] d);
    vec_t x;
    modelStep(r, en, clr, v, d);
    x.tag = tag; x.rst = r; x.enable = en; x.clear = clr; x.valid = v; x.data = d;
    x.exp_locked = m_locked;
    x.exp_error  = m_error;
    x.exp_bits   = m_bits;
    x.exp_ecnt   = m_ecnt[CW-1:0];
    x.exp_wcnt   = m_wcnt[CW-1:0];
    vecs.push_back(x);
  endtask

  task automatic checkField(input string tag, input string name,
                            input logic [CW-1:0] act, input logic [CW-1:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", tag, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    enable     = v.enable;
    clear      = v.clear;
    data_valid = v.valid;
    data_in    = v.data;
  endtask

  task automatic checkOutput(input vec_t v);
    checkField(v.tag, "locked",      32'(locked),     32'(v.exp_locked));
    checkField(v.tag, "error",       32'(error),      32'(v.exp_error));
    checkField(v.tag, "error_bits",  32'(error_bits), 32'(v.exp_bits));
    checkField(v.tag, "error_count", error_count,     v.exp_ecnt);
    checkField(v.tag, "word_count",  word_count,      v.exp_wcnt);
  endtask

  task automatic runVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i]);
    end
    vecs.delete();
  endtask

  // Main sequence
  initial begin
    logic [DW-1:0] w;
    bit            en_r;
    bit            clr_r;
    bit            v_r;
    int            burst;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; data_valid = 1'b0; data_in = '0;
    gen_state = 31'h7FFFFFFF;
    burst = 0;

    // Reset, enable, then a clean stream: lock on the 20th valid word
    addVec("reset", 1, 0, 0, 0, 8'h00);
    addVec("reset", 1, 0, 0, 0, 8'h00);
    addVec("idle",  0, 0, 0, 0, 8'h00);
    addVec("enable", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 30; i++) begin
      w = genWord();
      addVec("lock", 0, 1, 0, 1, w);
    end
    runVectors();
    checkField("lock", "locked_after_30", 32'(locked), 32'd1);
    checkField("lock", "words_after_lock", word_count, 32'd10);

    // Single flipped bit while locked
    w = genWord();
    addVec("bit3", 0, 1, 0, 1, w ^ 8'h08);
    for (int i = 0; i < 5; i++) begin
      w = genWord();
      addVec("bit3_after", 0, 1, 0, 1, w);
    end
    runVectors();
    checkField("bit3", "error_count", error_count, 32'd1);
    checkField("bit3", "word_count",  word_count,  32'd16);
    checkField("bit3", "locked",      32'(locked), 32'd1);

    // Four all-ones words unlock; clean stream relocks from SYNC
    for (int i = 0; i < 4; i++) begin
      w = genWord();
      addVec("burst", 0, 1, 0, 1, 8'hFF);
    end
    for (int i = 0; i < 20; i++) begin
      w = genWord();
      addVec("relock", 0, 1, 0, 1, w);
    end
    runVectors();

    // Valid gap holds everything
    for (int i = 0; i < 10; i++) addVec("gap", 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i < 5; i++) begin
      w = genWord();
      addVec("gap_after", 0, 1, 0, 1, w);
    end
    runVectors();

    // Counter saturation and clear-with-word
    force dut.error_count = 32'hFFFFFFFE;
    #1;
    release dut.error_count;
    m_ecnt = 64'h00000000FFFFFFFE;
    w = genWord();
    addVec("sat2", 0, 1, 0, 1, w ^ 8'h81);
    w = genWord();
    addVec("sat_clean", 0, 1, 0, 1, w);
    w = genWord();
    addVec("sat1", 0, 1, 0, 1, w ^ 8'h10);
    w = genWord();
    addVec("sat_clean", 0, 1, 0, 1, w);
    w = genWord();
    addVec("clear_word", 0, 1, 1, 1, w ^ 8'h01);
    for (int i = 0; i < 3; i++) begin
      w = genWord();
      addVec("post_clear", 0, 1, 0, 1, w);
    end
    runVectors();

    // Randomised traffic: gaps, bit flips, error bursts, clears, enable drops
    for (int c = 0; c < 400; c++) begin
      en_r  = ($urandom_range(0, 199) != 0);
      clr_r = ($urandom_range(0, 39) == 0);
      v_r   = ($urandom_range(0, 3) != 0);
      if (v_r) begin
        w = genWord();
        if (burst > 0) begin
          w = 8'hFF;
          burst--;
        end else if ($urandom_range(0, 15) == 0) begin
          w = w ^ 8'(1 << $urandom_range(0, 7));
        end else if ($urandom_range(0, 59) == 0) begin
          burst = UNLOCKN;
        end
      end else begin
        w = 8'($urandom);
      end
      addVec("random", 0, en_r, clr_r, v_r, w);
    end
    runVectors();

    // Relock, drop enable, relock, then reset while locked
    for (int i = 0; i < 40; i++) begin
      w = genWord();
      addVec("pre_drop", 0, 1, 0, 1, w);
    end
    runVectors();
    checkField("pre_drop", "locked", 32'(locked), 32'd1);
    w = genWord();
    addVec("drop_en", 0, 0, 0, 1, w);
    runVectors();
    checkField("drop_en", "locked", 32'(locked), 32'd0);
    addVec("reenable", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 25; i++) begin
      w = genWord();
      addVec("relock2", 0, 1, 0, 1, w);
    end
    w = genWord();
    addVec("rst_locked", 1, 1, 0, 1, w);
    runVectors();
    checkField("rst_locked", "locked",      32'(locked), 32'd0);
    checkField("rst_locked", "error_count", error_count, 32'd0);
    checkField("rst_locked", "word_count",  word_count,  32'd0);
    addVec("after_rst", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 19; i++) begin
      w = genWord();
      addVec("refill", 0, 1, 0, 1, w);
    end
    runVectors();
    checkField("refill", "locked_at_19", 32'(locked), 32'd0);
    w = genWord();
    addVec("refill_20", 0, 1, 0, 1, w);
    runVectors();
    checkField("refill", "locked_at_20", 32'(locked), 32'd1);
    checkField("refill", "word_count",   word_count,  32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/prbs_check_ctrl.md
Name: prbs_check_ctrl

Overview:
- Sequencing controller for the combinational lfsr core, used as a PRBS31 (x^31+x^28+1, Fibonacci) receive-side checker.
- Accepts a word-wide data stream and self-synchronises a seed register from the received bits.
- Drives the lfsr core to predict each next word, compares against received data, and runs a lock state machine.
- Sits behind a SERDES/loopback deserialiser; reports lock status, per-word error bits and saturating bit-error and word counters to a CSR block.

Parameters:
- LFSR_WIDTH, 31, PRBS state width.
- LFSR_POLY, 31'h10000001, feedback polynomial passed to the lfsr instance.
- DATA_WIDTH, 8, received word width; must satisfy 1 <= DATA_WIDTH < LFSR_WIDTH.
- LOCK_COUNT, 16, consecutive error-free words required in SYNC to enter LOCKED.
- UNLOCK_COUNT, 4, consecutive errored words in LOCKED that force return to SYNC.
- CNT_WIDTH, 32, width of error_count and word_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  checker enable; low forces IDLE
- clear  in  1  one-cycle pulse; zeroes both counters
- data_in  in  DATA_WIDTH  received word, earliest bit in MSB
- data_valid  in  1  data_in qualifier
- locked  out  1  high while in LOCKED
- error  out  1  one-cycle pulse: checked word had at least one mismatch
- error_bits  out  DATA_WIDTH  XOR of received vs predicted for the last checked word
- error_count  out  CNT_WIDTH  saturating count of mismatched bits while LOCKED
- word_count  out  CNT_WIDTH  saturating count of words checked while LOCKED

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset values: all outputs 0, FSM IDLE, seed register 0, all internal counters 0.
- Outputs are registered and update on the clk edge that consumes a valid word (latency 1).
- Prediction: the lfsr instance takes state_in = seed register and data_in = 0.
  - Its data_out is the predicted word.
  - Its state_out is the free-running next seed.
- Received-bit load: seed_next = {seed[LFSR_WIDTH-1-DATA_WIDTH:0], data_in}.
- FSM states:
  - IDLE: entered on reset or when enable is low; exits to FILL when enable is high.
  - FILL: load the seed from received bits.
    - Count ceil(LFSR_WIDTH/DATA_WIDTH) valid words (4 at defaults), with no comparison.
    - Then go to SYNC.
  - SYNC: compare every valid word and load the seed from received bits (self-sync).
    - A clean word increments the clean counter.
    - An errored word zeroes the clean counter.
    - When the clean counter reaches LOCK_COUNT, go to LOCKED.
    - Counters and error outputs are not updated in SYNC.
  - LOCKED: seed advances from lfsr state_out (free-running, no error multiplication).
    - Each valid word: word_count += 1; error_count += popcount(error_bits); error pulses if error_bits != 0.
    - An errored word increments the bad counter; a clean word zeroes it.
    - When the bad counter reaches UNLOCK_COUNT, go to SYNC. The clean counter is zeroed and locked falls on the same edge.
- data_valid low: no state, counter or seed change; error = 0.
- Counters saturate at all-ones and never wrap.
- clear together with a counted word: the counter is cleared, then that word is applied (word_count = 1, error_count = that word's popcount).
- enable low mid-operation: IDLE on the next edge, locked = 0. Counters are held (only rst/clear zero them). The seed is discarded and FILL restarts when enable rises.
- rst mid-operation overrides everything.

Decomposition:
- Shared package prbs_pkg holds:
  - FSM state encoding (IDLE, FILL, SYNC, LOCKED);
  - default PRBS31 width/polynomial constants;
  - a popcount function.
- One sub-module: the existing lfsr, instantiated with LFSR_CONFIG "FIBONACCI", REVERSE 0, STYLE "AUTO", used as the predictor.
- FSM, counters and compare logic stay in prbs_check_ctrl.

Test Plan:
- Reset, then enable with a clean PRBS31 stream (bench generator is an lfsr seeded 31'h7FFFFFFF, one word per cycle) -> locked rises after the 20th valid word (4 fill + 16 clean). error_count = 0; word_count increments by 1 per word.
- While locked, flip bit 3 of one word -> one error pulse, error_bits = 8'h08, error_count = 1, locked stays 1; following words are clean.
- While locked, send 4 consecutive words of 8'hFF -> locked falls on the 4th. Resuming the clean stream relocks after 16 clean words with no FILL.
- Gap data_valid low for 10 cycles mid-stream -> no counter change and lock retained; the stream continues seamlessly.
- Force error_count to 32'hFFFFFFFE (bench force), then inject a 2-bit error -> saturates at 32'hFFFFFFFF. A clear pulse coincident with a 1-bit error word -> error_count = 1, word_count = 1.
- Drop enable, then assert rst while locked -> locked = 0 next cycle. rst zeroes the counters; re-enable requires the full FILL + SYNC sequence again.
